// File: rtl/alu_pkg.sv
// alu_pkg: shared instruction-field layout, FSM states and flag bit indices for the ALU issue controller.
package alu_pkg;
    localparam int DEF_WIDTH   = 5;
    localparam int DEF_CTRL_W  = 3;
    localparam int DEF_SHIFT_W = 2;
    localparam int A_LSB       = 0;
    localparam int B_LSB       = DEF_WIDTH;
    localparam int CTRL_LSB    = 2 * DEF_WIDTH;
    localparam int SHIFT_LSB   = CTRL_LSB + DEF_CTRL_W;
    localparam int SEL_BIT     = SHIFT_LSB + DEF_SHIFT_W;
    localparam int USE_BIT     = SEL_BIT + 1;
    localparam int FLAG_N      = 3;
    localparam int FLAG_Z      = 2;
    localparam int FLAG_C      = 1;
    localparam int FLAG_V      = 0;
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
endpackage

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts packed ALU instructions, drives the shift+ALU datapath from registers
// and returns the captured result/flags over a valid/ready port, with optional result chaining.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CTRL_W  = DEF_CTRL_W,
    parameter int SHIFT_W = DEF_SHIFT_W
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [2*WIDTH+CTRL_W+SHIFT_W+2-1:0]   in_instr,
    output logic [WIDTH-1:0]                      dp_a,
    output logic [WIDTH-1:0]                      dp_b,
    output logic [CTRL_W-1:0]                     dp_alucontrol,
    output logic [SHIFT_W-1:0]                    dp_bshift,
    output logic                                  dp_select,
    input  logic [WIDTH-1:0]                      dp_result,
    input  logic [3:0]                            dp_flags,
    output logic                                  res_valid,
    input  logic                                  res_ready,
    output logic [WIDTH-1:0]                      res_data,
    output logic [3:0]                            res_flags,
    output logic [7:0]                            op_count
);
    localparam int B_OFF  = WIDTH;
    localparam int C_OFF  = 2 * WIDTH;
    localparam int S_OFF  = C_OFF + CTRL_W;
    localparam int SEL_OF = S_OFF + SHIFT_W;
    localparam int USE_OF = SEL_OF + 1;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    a_q, a_d, b_q, b_d, res_q, res_d, prev_q, prev_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [SHIFT_W-1:0]  shift_q, shift_d;
    logic                sel_q, sel_d;
    logic [3:0]          flags_q, flags_d;
    logic [7:0]          cnt_q, cnt_d;

    // Gated by rst_n so the port reads 0 while reset is held and rises once it is released.
    assign in_ready      = (state_q == IDLE) && rst_n;
    assign res_valid     = (state_q == DONE);
    assign dp_a          = a_q;
    assign dp_b          = b_q;
    assign dp_alucontrol = ctrl_q;
    assign dp_bshift     = shift_q;
    assign dp_select     = sel_q;
    assign res_data      = res_q;
    assign res_flags     = flags_q;
    assign op_count      = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= '0;
            shift_q <= '0;
            sel_q   <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
            prev_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctrl_q  <= ctrl_d;
            shift_q <= shift_d;
            sel_q   <= sel_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ctrl_d  = ctrl_q;
        shift_d = shift_q;
        sel_d   = sel_q;
        res_d   = res_q;
        flags_d = flags_q;
        prev_d  = prev_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE && in_valid) begin
            state_d = EXEC;
            a_d     = in_instr[USE_OF] ? prev_q : in_instr[WIDTH-1:0];
            b_d     = in_instr[B_OFF +: WIDTH];
            ctrl_d  = in_instr[C_OFF +: CTRL_W];
            shift_d = in_instr[S_OFF +: SHIFT_W];
            sel_d   = in_instr[SEL_OF];
        end
        if (state_q == EXEC) begin
            state_d = DONE;
            res_d   = dp_result;
            flags_d = dp_flags;
            prev_d  = dp_result;
        end
        if (state_q == DONE && res_ready) begin
            state_d = IDLE;
            cnt_d   = cnt_q + 8'd1;
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench for alu_issue_ctrl with an adder stub standing in for the datapath.
module tb_alu_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        res_ready = 1'b0;
    logic [16:0] in_instr = '0;
    logic        in_ready, dp_select, res_valid;
    logic [4:0]  dp_a, dp_b, dp_result, res_data;
    logic [2:0]  dp_alucontrol;
    logic [1:0]  dp_bshift;
    logic [3:0]  dp_flags, res_flags;
    logic [7:0]  op_count;
    int checks = 0;
    int errors = 0;

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .dp_a(dp_a), .dp_b(dp_b), .dp_alucontrol(dp_alucontrol), .dp_bshift(dp_bshift),
        .dp_select(dp_select), .dp_result(dp_result), .dp_flags(dp_flags),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_flags(res_flags), .op_count(op_count)
    );

    always #5 clk = ~clk;
    assign dp_result = dp_a + dp_b;
    assign dp_flags  = 4'b0101;

    function automatic logic [16:0] mk(input logic u, input logic s, input logic [1:0] sh,
                                       input logic [2:0] c, input logic [4:0] b, input logic [4:0] a);
        return {u, s, sh, c, b, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        res_ready = 1'b0;
        rst_n     = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Issues one instruction, waits (bounded) for the result and accepts it.
    task automatic run_op(input logic [16:0] instr, output logic [4:0] data);
        int n;
        in_valid = 1'b1;
        in_instr = instr;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!res_valid && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (!res_valid) begin
            errors++;
            $display("FAIL run_op_timeout res_valid got 0 exp 1");
        end
        data = res_data;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({in_ready, res_valid, dp_a, dp_b, dp_alucontrol, dp_bshift, dp_select, res_data, res_flags, op_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got in_ready=%0b res_valid=%0b dp_a=%0d res_data=%0d op_count=%0d exp all 0",
                     in_ready, res_valid, dp_a, res_data, op_count);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %0b exp 1", in_ready);
        end
    endtask

    task automatic test_single();
        in_valid = 1'b1;
        in_instr = mk(1'b0, 1'b1, 2'd2, 3'b010, 5'd4, 5'd3);
        tick();
        in_valid = 1'b0;
        checks++;
        if ({dp_a, dp_b, dp_alucontrol, dp_bshift, dp_select} !== {5'd3, 5'd4, 3'd2, 2'd2, 1'b1}) begin
            errors++;
            $display("FAIL single_dp got a=%0d b=%0d c=%0d sh=%0d sel=%0b exp 3 4 2 2 1",
                     dp_a, dp_b, dp_alucontrol, dp_bshift, dp_select);
        end
        checks++;
        if (in_ready !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_exec_hs got in_ready=%0b res_valid=%0b exp 0 0", in_ready, res_valid);
        end
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_data !== 5'd7 || res_flags !== 4'b0101) begin
            errors++;
            $display("FAIL single_result got v=%0b d=%0d f=%b exp 1 7 0101", res_valid, res_data, res_flags);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1 || op_count !== 8'd1) begin
            errors++;
            $display("FAIL single_accept got v=%0b rdy=%0b cnt=%0d exp 0 1 1", res_valid, in_ready, op_count);
        end
    endtask

    task automatic test_chain();
        logic [4:0] d;
        do_reset();
        run_op(mk(1'b0, 1'b0, 2'd0, 3'd0, 5'd5, 5'd10), d);
        checks++;
        if (d !== 5'd15) begin
            errors++;
            $display("FAIL chain_first got %0d exp 15", d);
        end
        in_valid = 1'b1;
        in_instr = mk(1'b1, 1'b0, 2'd1, 3'd1, 5'd20, 5'd1);
        tick();
        in_valid = 1'b0;
        checks++;
        if (dp_a !== 5'd15) begin
            errors++;
            $display("FAIL chain_dp_a got %0d exp 15", dp_a);
        end
        tick();
        checks++;
        if (res_data !== 5'd3) begin
            errors++;
            $display("FAIL chain_result got %0d exp 3", res_data);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checks++;
        if (op_count !== 8'd2) begin
            errors++;
            $display("FAIL chain_count got %0d exp 2", op_count);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] c0;
        c0 = op_count;
        in_valid = 1'b1;
        in_instr = mk(1'b0, 1'b0, 2'd0, 3'd0, 5'd2, 5'd1);
        tick();
        in_instr = mk(1'b0, 1'b1, 2'd3, 3'd7, 5'd4, 5'd4);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (res_valid !== 1'b1 || res_data !== 5'd3 || in_ready !== 1'b0 || dp_a !== 5'd1 || dp_b !== 5'd2) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got v=%0b d=%0d rdy=%0b a=%0d b=%0d exp 1 3 0 1 2",
                         i, res_valid, res_data, in_ready, dp_a, dp_b);
            end
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || op_count !== c0 + 8'd1) begin
            errors++;
            $display("FAIL bp_release got rdy=%0b cnt=%0d exp 1 %0d", in_ready, op_count, c0 + 8'd1);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (dp_a !== 5'd4 || dp_select !== 1'b1 || dp_alucontrol !== 3'd7) begin
            errors++;
            $display("FAIL bp_next_load got a=%0d sel=%0b c=%0d exp 4 1 7", dp_a, dp_select, dp_alucontrol);
        end
        tick();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (res_valid !== 1'b0 || op_count !== c0 + 8'd2) begin
            errors++;
            $display("FAIL bp_single_accept got v=%0b cnt=%0d exp 0 %0d", res_valid, op_count, c0 + 8'd2);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [4:0] d;
        do_reset();
        in_valid = 1'b1;
        in_instr = mk(1'b0, 1'b0, 2'd0, 3'd0, 5'd7, 5'd7);
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (res_valid !== 1'b0 || dp_a !== 5'd0 || op_count !== 8'd0) begin
            errors++;
            $display("FAIL midop_reset got v=%0b a=%0d cnt=%0d exp 0 0 0", res_valid, dp_a, op_count);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (res_valid !== 1'b0) begin
                errors++;
                $display("FAIL midop_no_result cycle %0d got 1 exp 0", i);
            end
        end
        run_op(mk(1'b1, 1'b0, 2'd0, 3'd0, 5'd9, 5'd31), d);
        checks++;
        if (d !== 5'd9) begin
            errors++;
            $display("FAIL midop_prev_cleared got %0d exp 9", d);
        end
    endtask

    task automatic test_wrap();
        logic [4:0] d;
        do_reset();
        for (int i = 0; i < 255; i++) run_op(mk(1'b0, 1'b0, 2'd0, 3'd0, 5'd1, 5'd1), d);
        checks++;
        if (op_count !== 8'd255) begin
            errors++;
            $display("FAIL wrap_255 got %0d exp 255", op_count);
        end
        run_op(mk(1'b0, 1'b0, 2'd0, 3'd0, 5'd1, 5'd1), d);
        checks++;
        if (op_count !== 8'd0) begin
            errors++;
            $display("FAIL wrap_0 got %0d exp 0", op_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_chain();
        test_backpressure();
        test_reset_mid_op();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
